// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display path.
// Segment vectors are active-low and ordered {a,b,c,d,e,f,g} from bit 6 down to bit 0.
package seg7_pkg;

    // Bit position of each segment inside a seg[6:0] vector.
    typedef enum logic [2:0] {
        SEG_G = 3'd0,
        SEG_F = 3'd1,
        SEG_E = 3'd2,
        SEG_D = 3'd3,
        SEG_C = 3'd4,
        SEG_B = 3'd5,
        SEG_A = 3'd6
    } seg_pos_e;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, a lit segment is 0.
    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h60;
    localparam logic [6:0] GLYPH_C = 7'h31;
    localparam logic [6:0] GLYPH_D = 7'h42;
    localparam logic [6:0] GLYPH_E = 7'h30;
    localparam logic [6:0] GLYPH_F = 7'h38;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: purely combinational hex nibble to active-low segment decoder.
module seg7_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Map the nibble onto its glyph; the default keeps the output defined on X.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex7seg_scan.sv
// hex7seg_scan: multiplexed hex display driver. Inputs are captured into a
// shadow register on load; everything shown is derived from that shadow so a
// scan never mixes old and new data. Outputs are registered one cycle behind
// the scan index.
module hex7seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);
    import seg7_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_wrap_q, frame_wrap_d;
    logic                    cnt_wrap;

    // Shadow copy of the display contents
    logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;

    // Currently selected digit
    logic [3:0]              cur_nibble;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_an_low;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [6:0]              decoded_seg;

    // Registered outputs
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    // Refresh counter and digit index; the index steps only when the counter wraps.
    always_comb begin
        cnt_wrap     = (cnt_q == CNT_LAST);
        cnt_d        = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        frame_wrap_d = cnt_wrap && (idx_q == IDX_LAST);
    end

    // Shadow register captures the whole display image on load and holds otherwise.
    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_en_d    = shadow_en_q;
        if (load) begin
            shadow_value_d = value;
            shadow_dp_d    = dp_in;
            shadow_en_d    = digit_en;
        end
    end

    // Leading-zero mask: digit i (never digit 0) is blanked when it and every higher nibble are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = LZ_BLANK && (i != 0) && upper_zero;
        end
    end

    // Select the shadow fields of the current digit and build its one-hot-low anode pattern.
    always_comb begin
        cur_nibble = 4'h0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_an_low = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble    = shadow_value_q[4*i +: 4];
                cur_en        = shadow_en_q[i];
                cur_dp        = shadow_dp_q[i];
                cur_blank     = lz_mask[i];
                cur_an_low[i] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (decoded_seg)
    );

    // Next output image: a disabled digit is fully dark, a blanked digit keeps its anode and dp.
    always_comb begin
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_tick_d = frame_wrap_q;
        if (cur_en) begin
            an_d  = cur_an_low;
            dp_d  = ~cur_dp;
            seg_d = cur_blank ? SEG_OFF : decoded_seg;
        end
    end

    // All state updates; reset wins over load and counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            frame_wrap_q   <= 1'b0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_en_q    <= '0;
            seg_q          <= SEG_OFF;
            dp_q           <= 1'b1;
            an_q           <= '1;
            frame_tick_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            frame_wrap_q   <= frame_wrap_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex7seg_scan.sv
// tb_hex7seg_scan: drives three display instances (4 digits plain, 4 digits
// with leading-zero blanking, 1 digit at full refresh rate) from one stimulus
// stream. A reference model queues the expected outputs each clock and a
// monitor compares them half a cycle later; directed checks cover the
// worked examples with literal glyph values.
module tb_hex7seg_scan;

    localparam int R = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b;
    logic [0:0]  an_c;
    logic        ft_a, ft_b, ft_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hex7seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(R), .LZ_BLANK(1'b0)) dut_a (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
    );

    hex7seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(R), .LZ_BLANK(1'b1)) dut_b (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
    );

    hex7seg_scan #(.NUM_DIGITS(1), .REFRESH_DIV(1), .LZ_BLANK(1'b1)) dut_c (
        .clk(clk), .reset(reset), .value(value[3:0]), .dp_in(dp_in[0:0]), .digit_en(digit_en[0:0]),
        .load(load), .seg(seg_c), .dp(dp_c), .an(an_c), .frame_tick(ft_c)
    );

    typedef struct {
        int         unit;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] an;
        logic       ft;
    } exp_t;

    exp_t        sb_q[$];
    bit          model_valid = 1'b0;
    int          since = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    logic [3:0]  m_en  = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    // k is the number of non-reset edges since the last reset edge, counting this one.
    function automatic exp_t predict(input int unit, input int nd, input int rd, input bit lz, input int k,
                                     input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                                     input bit in_reset);
        exp_t x;
        int   digit;
        x.unit = unit;
        x.seg  = 7'h7F;
        x.dp   = 1'b1;
        x.an   = 8'hFF;
        x.ft   = 1'b0;
        if (!in_reset) begin
            digit = ((k - 1) / rd) % nd;
            x.ft  = (k > 1) && (((k - 1) % (rd * nd)) == 0);
            if (e[digit]) begin
                x.an = 8'hFF & ~(8'h01 << digit);
                x.dp = ~d[digit];
                if (lz && digit > 0 && (v >> (4 * digit)) == 16'h0)
                    x.seg = 7'h7F;
                else
                    x.seg = glyph(v[4*digit +: 4]);
            end
        end
        return x;
    endfunction

    // Reference model: queue what each instance must show after this edge.
    always @(posedge clk) begin
        if (reset) begin
            sb_q.push_back(predict(0, 4, R, 1'b0, 0, 16'h0, 4'h0, 4'h0, 1'b1));
            sb_q.push_back(predict(1, 4, R, 1'b1, 0, 16'h0, 4'h0, 4'h0, 1'b1));
            sb_q.push_back(predict(2, 1, 1, 1'b1, 0, 16'h0, 4'h0, 4'h0, 1'b1));
            model_valid <= 1'b1;
            since       <= 0;
            m_val       <= '0;
            m_dp        <= '0;
            m_en        <= '0;
        end else if (model_valid) begin
            sb_q.push_back(predict(0, 4, R, 1'b0, since + 1, m_val, m_dp, m_en, 1'b0));
            sb_q.push_back(predict(1, 4, R, 1'b1, since + 1, m_val, m_dp, m_en, 1'b0));
            sb_q.push_back(predict(2, 1, 1, 1'b1, since + 1, m_val & 16'h000F, m_dp & 4'h1, m_en & 4'h1, 1'b0));
            since <= since + 1;
            if (load) begin
                m_val <= value;
                m_dp  <= dp_in;
                m_en  <= digit_en;
            end
        end
    end

    // Scoreboard monitor: compare queued expectations on the falling edge.
    always @(negedge clk) begin
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            case (x.unit)
                0: begin
                    checkOutput("sb_a_seg", {25'b0, seg_a}, {25'b0, x.seg});
                    checkOutput("sb_a_dp", {31'b0, dp_a}, {31'b0, x.dp});
                    checkOutput("sb_a_an", {24'b0, 4'hF, an_a}, {24'b0, x.an});
                    checkOutput("sb_a_ft", {31'b0, ft_a}, {31'b0, x.ft});
                end
                1: begin
                    checkOutput("sb_b_seg", {25'b0, seg_b}, {25'b0, x.seg});
                    checkOutput("sb_b_dp", {31'b0, dp_b}, {31'b0, x.dp});
                    checkOutput("sb_b_an", {24'b0, 4'hF, an_b}, {24'b0, x.an});
                    checkOutput("sb_b_ft", {31'b0, ft_b}, {31'b0, x.ft});
                end
                default: begin
                    checkOutput("sb_c_seg", {25'b0, seg_c}, {25'b0, x.seg});
                    checkOutput("sb_c_dp", {31'b0, dp_c}, {31'b0, x.dp});
                    checkOutput("sb_c_an", {24'b0, 7'h7F, an_c}, {24'b0, x.an});
                    checkOutput("sb_c_ft", {31'b0, ft_c}, {31'b0, x.ft});
                end
            endcase
        end
    end

    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] v,
                                 input logic [3:0] d, input logic [3:0] e, input int cycles);
        reset    = rst;
        load     = ld;
        value    = v;
        dp_in    = d;
        digit_en = e;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitForTick(input string tag);
        int n;
        n = 0;
        while (ft_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_tick_seen"}, {31'b0, ft_a}, 32'd1);
    endtask

    // Walk one full frame from its first digit-0 cycle; digit d fields sit at [7*d +: 7] / [4*d +: 4].
    task automatic checkFrame(input string tag, input logic [27:0] seg_a_exp, input logic [27:0] seg_b_exp,
                              input logic [15:0] an_exp, input logic [3:0] dp_exp);
        @(negedge clk);
        waitForTick(tag);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < R; c++) begin
                checkOutput({tag, "_an_a"}, {28'b0, an_a}, {28'b0, an_exp[4*d +: 4]});
                checkOutput({tag, "_an_b"}, {28'b0, an_b}, {28'b0, an_exp[4*d +: 4]});
                checkOutput({tag, "_seg_a"}, {25'b0, seg_a}, {25'b0, seg_a_exp[7*d +: 7]});
                checkOutput({tag, "_seg_b"}, {25'b0, seg_b}, {25'b0, seg_b_exp[7*d +: 7]});
                checkOutput({tag, "_dp_a"}, {31'b0, dp_a}, {31'b0, dp_exp[d]});
                checkOutput({tag, "_ft_a"}, {31'b0, ft_a}, {31'b0, (d == 0 && c == 0)});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [15:0] rv;
        logic [3:0]  rd;
        logic [3:0]  re;

        applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 3);
        checkOutput("rst_an_a", {28'b0, an_a}, 32'hF);
        checkOutput("rst_seg_a", {25'b0, seg_a}, 32'h7F);
        checkOutput("rst_dp_a", {31'b0, dp_a}, 32'h1);
        checkOutput("rst_ft_a", {31'b0, ft_a}, 32'h0);
        checkOutput("rst_an_c", {31'b0, an_c}, 32'h1);

        applyStimulus(1'b0, 1'b1, 16'h12AF, 4'h0, 4'hF, 1);
        applyStimulus(1'b0, 1'b0, 16'h12AF, 4'h0, 4'hF, 0);
        checkFrame("scan", {7'h4F, 7'h12, 7'h08, 7'h38}, {7'h4F, 7'h12, 7'h08, 7'h38},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF);

        applyStimulus(1'b0, 1'b1, 16'h0050, 4'h0, 4'hF, 1);
        applyStimulus(1'b0, 1'b0, 16'h0050, 4'h0, 4'hF, 0);
        checkFrame("lz50", {7'h01, 7'h01, 7'h24, 7'h01}, {7'h7F, 7'h7F, 7'h24, 7'h01},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF);

        applyStimulus(1'b0, 1'b1, 16'h0000, 4'h0, 4'hF, 1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 4'hF, 0);
        checkFrame("lz00", {7'h01, 7'h01, 7'h01, 7'h01}, {7'h7F, 7'h7F, 7'h7F, 7'h01},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF);

        applyStimulus(1'b0, 1'b1, 16'h12AF, 4'b0100, 4'b0101, 1);
        applyStimulus(1'b0, 1'b0, 16'h12AF, 4'b0100, 4'b0101, 0);
        checkFrame("en_dp", {7'h7F, 7'h12, 7'h7F, 7'h38}, {7'h7F, 7'h12, 7'h7F, 7'h38},
                   {4'hF, 4'b1011, 4'hF, 4'b1110}, 4'b1011);

        applyStimulus(1'b0, 1'b0, 16'h3333, 4'h0, 4'hF, 0);
        checkFrame("noload", {7'h7F, 7'h12, 7'h7F, 7'h38}, {7'h7F, 7'h12, 7'h7F, 7'h38},
                   {4'hF, 4'b1011, 4'hF, 4'b1110}, 4'b1011);

        checkOutput("lat_start_an", {28'b0, an_a}, 32'hE);
        applyStimulus(1'b0, 1'b1, 16'h12A3, 4'b0100, 4'b0101, 1);
        checkOutput("lat_old_seg", {25'b0, seg_a}, 32'h38);
        applyStimulus(1'b0, 1'b0, 16'h12A3, 4'b0100, 4'b0101, 1);
        checkOutput("lat_new_seg", {25'b0, seg_a}, 32'h06);
        checkOutput("lat_new_an", {28'b0, an_a}, 32'hE);

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF, 1);
        checkOutput("midrst_an_a", {28'b0, an_a}, 32'hF);
        checkOutput("midrst_seg_a", {25'b0, seg_a}, 32'h7F);
        checkOutput("midrst_dp_a", {31'b0, dp_a}, 32'h1);
        checkOutput("midrst_ft_a", {31'b0, ft_a}, 32'h0);
        checkOutput("midrst_seg_c", {25'b0, seg_c}, 32'h7F);
        applyStimulus(1'b0, 1'b1, 16'h12AF, 4'h0, 4'hF, 1);
        checkOutput("resume_empty_an", {28'b0, an_a}, 32'hF);
        applyStimulus(1'b0, 1'b0, 16'h12AF, 4'h0, 4'hF, 1);
        checkOutput("resume_d0_an", {28'b0, an_a}, 32'hE);
        checkOutput("resume_d0_seg", {25'b0, seg_a}, 32'h38);
        applyStimulus(1'b0, 1'b0, 16'h12AF, 4'h0, 4'hF, 1);
        checkOutput("resume_d0_hold", {28'b0, an_a}, 32'hE);
        applyStimulus(1'b0, 1'b0, 16'h12AF, 4'h0, 4'hF, 1);
        checkOutput("resume_d1_an", {28'b0, an_a}, 32'hD);
        checkOutput("resume_d1_seg", {25'b0, seg_a}, 32'h08);

        for (int i = 0; i < 10; i++) begin
            rv = 16'($urandom);
            rd = 4'($urandom);
            re = 4'($urandom);
            applyStimulus(1'b0, 1'b1, rv, rd, re, 1);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 30);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
